// File: rtl/text_console_pkg.sv
// Shared definitions for the text console: screen geometry, control codes and FSM states.
package text_console_pkg;

  localparam int unsigned COLS         = 80;
  localparam int unsigned ROWS         = 25;
  localparam int unsigned CELLS        = COLS * ROWS;
  localparam int unsigned ROW_BYTES    = 2 * COLS;
  localparam int unsigned SCREEN_BYTES = 2 * CELLS;

  localparam logic [7:0] CC_BS = 8'h08;
  localparam logic [7:0] CC_LF = 8'h0A;
  localparam logic [7:0] CC_FF = 8'h0C;
  localparam logic [7:0] CC_CR = 8'h0D;

  typedef enum logic [2:0] {
    StIdle,
    StWChar,
    StWAttr,
    StClear,
    StScRd,
    StScWr,
    StFill
  } state_e;

  function automatic logic is_ctrl(input logic [7:0] b);
    return (b == CC_BS) || (b == CC_LF) || (b == CC_FF) || (b == CC_CR);
  endfunction

endpackage

// File: rtl/text_fill.sv
// Pattern writer: emits count bytes from base, BLANK on even addresses and attr on odd ones.
module text_fill #(
  parameter logic [7:0] BLANK = 8'h20
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [11:0] base,
  input  logic [11:0] count,
  input  logic [7:0]  attr,
  output logic [11:0] address,
  output logic [7:0]  wdata,
  output logic        we,
  output logic        active,
  output logic        done
);

  logic        active_q;
  logic [11:0] offset_q;
  logic [11:0] base_q;
  logic [11:0] count_q;
  logic [7:0]  attr_q;
  logic        last;

  assign last = active_q && (offset_q == count_q - 12'd1);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      active_q <= 1'b0;
      offset_q <= '0;
      base_q   <= '0;
      count_q  <= '0;
      attr_q   <= '0;
    end else if (start) begin
      active_q <= 1'b1;
      offset_q <= '0;
      base_q   <= base;
      count_q  <= count;
      attr_q   <= attr;
    end else if (active_q) begin
      // Offset stops on the last byte so the address never runs past the region.
      if (last) begin
        active_q <= 1'b0;
      end else begin
        offset_q <= offset_q + 12'd1;
      end
    end
  end

  always_comb begin
    address = base_q + offset_q;
    we      = active_q;
    active  = active_q;
    done    = last;
    wdata   = 8'h00;
    if (active_q) begin
      wdata = address[0] ? attr_q : BLANK;
    end
  end

endmodule

// File: rtl/text_console.sv
// Terminal-style writer into 80x25 char/attr video RAM with cursor tracking and hardware scroll.
module text_console
  import text_console_pkg::*;
#(
  parameter logic [7:0] DEFAULT_ATTR = 8'h07,
  parameter logic [7:0] BLANK        = 8'h20
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        attr_we,
  input  logic [7:0]  attr_data,
  output logic [11:0] mem_address,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  input  logic [7:0]  mem_rdata,
  output logic [10:0] cursor,
  output logic        busy
);

  localparam logic [10:0] LastCell    = 11'(CELLS - 1);
  localparam logic [10:0] LastRowCell = 11'(CELLS - COLS);
  localparam logic [10:0] ColsW       = 11'(COLS);
  localparam logic [11:0] CellsW      = 12'(CELLS);
  localparam logic [11:0] RowBytesW   = 12'(ROW_BYTES);
  localparam logic [11:0] ScreenW     = 12'(SCREEN_BYTES);
  localparam logic [11:0] FillBaseW   = 12'(SCREEN_BYTES - ROW_BYTES);
  localparam logic [11:0] ScrollLastW = 12'(SCREEN_BYTES - ROW_BYTES - 1);

  state_e      state_q, state_d;
  logic [10:0] cursor_q, cursor_d;
  logic [11:0] idx_q, idx_d;
  logic [7:0]  char_q, char_d;
  logic [7:0]  char_attr_q, char_attr_d;
  logic [7:0]  attr_q;
  logic [11:0] last_addr_q;
  logic [11:0] lf_sum;

  logic        fill_start;
  logic [11:0] fill_base;
  logic [11:0] fill_count;
  logic [11:0] fill_address;
  logic [7:0]  fill_wdata;
  logic        fill_we;
  logic        fill_active;
  logic        fill_done;

  text_fill #(
    .BLANK(BLANK)
  ) u_fill (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (fill_start),
    .base    (fill_base),
    .count   (fill_count),
    .attr    (attr_q),
    .address (fill_address),
    .wdata   (fill_wdata),
    .we      (fill_we),
    .active  (fill_active),
    .done    (fill_done)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= StClear;
      cursor_q    <= '0;
      idx_q       <= '0;
      char_q      <= '0;
      char_attr_q <= '0;
      attr_q      <= DEFAULT_ATTR;
      last_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      cursor_q    <= cursor_d;
      idx_q       <= idx_d;
      char_q      <= char_d;
      char_attr_q <= char_attr_d;
      last_addr_q <= mem_address;
      if (attr_we) begin
        attr_q <= attr_data;
      end
    end
  end

  assign lf_sum   = {1'b0, cursor_q} + {1'b0, ColsW};
  assign cursor   = cursor_q;
  assign in_ready = (state_q == StIdle);
  assign busy     = (state_q != StIdle);

  always_comb begin
    state_d     = state_q;
    cursor_d    = cursor_q;
    idx_d       = idx_q;
    char_d      = char_q;
    char_attr_d = char_attr_q;
    fill_start  = 1'b0;
    fill_base   = '0;
    fill_count  = ScreenW;
    mem_address = last_addr_q;
    mem_wdata   = '0;
    mem_we      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          case (in_data)
            CC_CR: cursor_d = cursor_q - (cursor_q % ColsW);
            CC_LF: begin
              // Past the last row the column is kept and the screen moves up instead.
              if (lf_sum >= CellsW) begin
                idx_d   = '0;
                state_d = StScRd;
              end else begin
                cursor_d = lf_sum[10:0];
              end
            end
            CC_BS: begin
              if (cursor_q != '0) begin
                cursor_d = cursor_q - 11'd1;
              end
            end
            CC_FF: begin
              fill_start = 1'b1;
              state_d    = StClear;
            end
            default: begin
              char_d      = in_data;
              char_attr_d = attr_q;
              state_d     = StWChar;
            end
          endcase
        end
      end

      StWChar: begin
        mem_address = {cursor_q, 1'b0};
        mem_wdata   = char_q;
        mem_we      = 1'b1;
        state_d     = StWAttr;
      end

      StWAttr: begin
        mem_address = {cursor_q, 1'b1};
        mem_wdata   = char_attr_q;
        mem_we      = 1'b1;
        if (cursor_q == LastCell) begin
          cursor_d = LastRowCell;
          idx_d    = '0;
          state_d  = StScRd;
        end else begin
          cursor_d = cursor_q + 11'd1;
          state_d  = StIdle;
        end
      end

      StClear: begin
        // Only idle here on the first cycle out of reset; FF starts the fill on accept.
        fill_start  = !fill_active;
        mem_address = fill_address;
        mem_wdata   = fill_wdata;
        mem_we      = fill_we;
        if (fill_done) begin
          cursor_d = '0;
          state_d  = StIdle;
        end
      end

      StScRd: begin
        mem_address = idx_q + RowBytesW;
        state_d     = StScWr;
      end

      StScWr: begin
        mem_address = idx_q;
        mem_wdata   = mem_rdata;
        mem_we      = 1'b1;
        if (idx_q == ScrollLastW) begin
          fill_start = 1'b1;
          fill_base  = FillBaseW;
          fill_count = RowBytesW;
          state_d    = StFill;
        end else begin
          idx_d   = idx_q + 12'd1;
          state_d = StScRd;
        end
      end

      StFill: begin
        mem_address = fill_address;
        mem_wdata   = fill_wdata;
        mem_we      = fill_we;
        if (fill_done) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_text_console.sv
// Directed plus randomized bench for text_console against a row-level screen model.
module tb_text_console;

  localparam int Limit = 20000;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        attr_we = 1'b0;
  logic [7:0]  attr_data = '0;
  logic [11:0] mem_address;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata = '0;
  logic [10:0] cursor;
  logic        busy;

  text_console dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .attr_we     (attr_we),
    .attr_data   (attr_data),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_we      (mem_we),
    .mem_rdata   (mem_rdata),
    .cursor      (cursor),
    .busy        (busy)
  );

  always #20 clock = ~clock;

  typedef struct {
    logic [11:0] a;
    logic [7:0]  d;
    int          c;
  } wr_t;

  logic [7:0] ram [0:4095];
  wr_t        wlog [$];
  int         cyc = 0;

  // External video RAM with one-cycle read latency, plus a log of every write.
  always @(posedge clock) begin
    cyc <= cyc + 1;
    mem_rdata <= ram[mem_address];
    if (mem_we === 1'b1) begin
      ram[mem_address] <= mem_wdata;
      wlog.push_back('{mem_address, mem_wdata, cyc + 1});
    end
  end

  // Reference screen: 25 rows of 80 (char, attr) cells.
  logic [7:0] ref_scr [0:3999];
  int         ref_cur;
  logic [7:0] ref_attr;

  int tests = 0;
  int fails = 0;
  int low;
  int base;
  int n;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic ref_clear_row(input int r);
    for (int c = 0; c < 80; c++) begin
      ref_scr[(r * 80 + c) * 2]     = 8'h20;
      ref_scr[(r * 80 + c) * 2 + 1] = ref_attr;
    end
  endtask

  task automatic ref_scroll();
    for (int r = 0; r < 24; r++)
      for (int b = 0; b < 160; b++) ref_scr[r * 160 + b] = ref_scr[(r + 1) * 160 + b];
    ref_clear_row(24);
  endtask

  task automatic ref_apply(input logic [7:0] b);
    case (b)
      8'h0D: ref_cur = (ref_cur / 80) * 80;
      8'h0A: if (ref_cur + 80 >= 2000) ref_scroll(); else ref_cur += 80;
      8'h08: if (ref_cur > 0) ref_cur--;
      8'h0C: begin
        for (int r = 0; r < 25; r++) ref_clear_row(r);
        ref_cur = 0;
      end
      default: begin
        ref_scr[ref_cur * 2]     = b;
        ref_scr[ref_cur * 2 + 1] = ref_attr;
        ref_cur++;
        if (ref_cur == 2000) begin
          ref_scroll();
          ref_cur = 1920;
        end
      end
    endcase
  endtask

  task automatic ref_reset();
    ref_attr = 8'h07;
    for (int r = 0; r < 25; r++) ref_clear_row(r);
    ref_cur = 0;
  endtask

  task automatic compare_ram(input string tag);
    int bad = 0;
    for (int i = 0; i < 4000; i++) if (ram[i] !== ref_scr[i]) bad++;
    check(tag, bad, 0);
  endtask

  task automatic wait_ready(output int cycles);
    cycles = 0;
    while (in_ready !== 1'b1 && cycles < Limit) begin
      @(posedge clock); #1;
      cycles++;
    end
    check("ready_timeout", cycles < Limit, 1);
  endtask

  // Waits for idle, offers one byte (optionally with a same-cycle attr load), measures busy time.
  task automatic send(input logic [7:0] b, input bit do_attr, input logic [7:0] na,
                      output int busy_cycles);
    int w;
    wait_ready(w);
    in_data   = b;
    in_valid  = 1'b1;
    attr_we   = do_attr;
    attr_data = na;
    @(posedge clock); #1;
    in_valid = 1'b0;
    attr_we  = 1'b0;
    ref_apply(b);
    if (do_attr) ref_attr = na;
    busy_cycles = 0;
    while (in_ready !== 1'b1 && busy_cycles < Limit) begin
      @(posedge clock); #1;
      busy_cycles++;
    end
  endtask

  task automatic put(input logic [7:0] b);
    int l;
    send(b, 1'b0, 8'h00, l);
  endtask

  task automatic set_attr(input logic [7:0] v);
    attr_we   = 1'b1;
    attr_data = v;
    @(posedge clock); #1;
    attr_we  = 1'b0;
    ref_attr = v;
  endtask

  function automatic logic [7:0] rand_char();
    logic [7:0] c = 8'($urandom);
    if (c == 8'h08 || c == 8'h0A || c == 8'h0C || c == 8'h0D) c = c | 8'h40;
    return c;
  endfunction

  initial begin
    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_address, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_cursor", cursor, 0);
    check("rst_ready", in_ready, 0);
    check("rst_busy", busy, 1);
    reset_n = 1'b1;
    ref_reset();
    base = wlog.size();
    wait_ready(n);
    check("clr_writes", wlog.size() - base, 4000);
    check("clr_ready_edge", cyc, wlog[wlog.size() - 1].c);
    check("clr_cursor", cursor, 0);
    compare_ram("clr_dump");

    // Attribute load then one printable
    set_attr(8'h1E);
    base = wlog.size();
    send(8'h41, 1'b0, 8'h00, low);
    check("a_w0_addr", wlog[base].a, 0);
    check("a_w0_data", wlog[base].d, 8'h41);
    check("a_w1_addr", wlog[base + 1].a, 1);
    check("a_w1_data", wlog[base + 1].d, 8'h1E);
    check("a_consec", wlog[base + 1].c, wlog[base].c + 1);
    check("a_low", low, 2);
    check("a_cursor", cursor, 1);

    // Control codes from cursor 85
    put(8'h0A);
    for (int k = 0; k < 4; k++) put(rand_char());
    check("cc_start", cursor, 85);
    base = wlog.size();
    put(8'h0D);
    check("cc_cr", cursor, 80);
    put(8'h0A);
    check("cc_lf", cursor, 160);
    put(8'h08);
    check("cc_bs", cursor, 159);
    check("cc_nowrite", wlog.size() - base, 0);
    send(8'h0C, 1'b0, 8'h00, low);
    check("ff_low", low, 4000);
    check("ff_cursor", cursor, 0);
    base = wlog.size();
    put(8'h08);
    check("bs_zero", cursor, 0);
    check("bs_nowrite", wlog.size() - base, 0);
    compare_ram("ff_dump");

    // Bottom-right printable: row 1 of 'B', cursor to 1999
    send(8'h0A, 1'b1, 8'h07, low);
    for (int k = 0; k < 80; k++) put(8'h42);
    for (int k = 0; k < 22; k++) put(8'h0A);
    for (int k = 0; k < 79; k++) put(rand_char());
    check("br_start", cursor, 1999);
    set_attr(8'h4F);
    base = wlog.size();
    send(8'h5A, 1'b0, 8'h00, low);
    check("br_w0_addr", wlog[base].a, 3998);
    check("br_w0_data", wlog[base].d, 8'h5A);
    check("br_w1_addr", wlog[base + 1].a, 3999);
    check("br_w1_data", wlog[base + 1].d, 8'h4F);
    check("br_busy", low, 2 + 7680 + 160);
    check("br_writes", wlog.size() - base, 2 + 3840 + 160);
    check("br_cursor", cursor, 1920);
    check("br_row0_c", ram[0], 8'h42);
    check("br_row0_a", ram[159], 8'h07);
    check("br_fill_c", ram[3840], 8'h20);
    check("br_fill_a", ram[3999], 8'h4F);
    compare_ram("br_dump");

    // LF at 1925 with the next byte already offered
    for (int k = 0; k < 5; k++) put(rand_char());
    check("lf_start", cursor, 1925);
    in_data  = 8'h0A;
    in_valid = 1'b1;
    @(posedge clock); #1;
    ref_apply(8'h0A);
    in_data = 8'h51;
    n = 0;
    while (in_ready !== 1'b1 && n < Limit) begin
      @(posedge clock); #1;
      n++;
    end
    check("lf_held_off", n, 7840);
    check("lf_cursor", cursor, 1925);
    @(posedge clock); #1;
    in_valid = 1'b0;
    ref_apply(8'h51);
    wait_ready(n);
    check("lf_next_cursor", cursor, 1926);
    compare_ram("lf_dump");

    // Randomized traffic, including attr loads in the accept cycle
    put(8'h0C);
    for (int k = 0; k < 120; k++) begin
      int r = int'($urandom_range(0, 99));
      logic [7:0] b;
      if (r < 6) b = 8'h0A;
      else if (r < 9) b = 8'h0D;
      else if (r < 13) b = 8'h08;
      else b = rand_char();
      send(b, ($urandom_range(0, 3) == 0), 8'($urandom), low);
      check("rand_cursor", cursor, ref_cur);
    end
    compare_ram("rand_dump");

    // Reset in the middle of a scroll
    set_attr(8'h5C);
    for (int k = 0; k < 25 && ref_cur < 1920; k++) put(8'h0A);
    in_data  = 8'h0A;
    in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (2000) @(posedge clock);
    #1;
    check("mid_busy", busy, 1);
    reset_n = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    check("mid_we", mem_we, 0);
    check("mid_cursor", cursor, 0);
    check("mid_ready", in_ready, 0);
    ref_reset();
    base = wlog.size();
    wait_ready(n);
    check("mid_clr_writes", wlog.size() - base, 4000);
    base = wlog.size();
    put(8'h58);
    check("mid_attr", wlog[base + 1].d, 8'h07);
    compare_ram("mid_dump");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/text_console.md
Name: text_console

Overview:
- Upstream writer for the 80x25 text-mode video RAM scanned by the VGA text generator.
- Accepts a byte stream over a valid/ready handshake and interprets it as a terminal: printable characters, CR, LF, BS, FF.
- Writes char/attr byte pairs to video RAM: even address holds the char, odd address holds the attr.
- Exports the cursor cell index that the generator blinks, and scrolls the screen when output runs off the bottom.

Parameters:
- COLS, 80, characters per row.
- ROWS, 25, rows per screen. COLS*ROWS must be ≤ 2048.
- DEFAULT_ATTR, 8'h07, attribute register value after reset.
- BLANK, 8'h20, character used for clear and fill.

Ports:
- clock  in  1  system clock (25 MHz)
- reset_n  in  1  synchronous active-low reset
- in_data  in  8  byte to print or control code
- in_valid  in  1  in_data valid
- in_ready  out  1  block can accept a byte
- attr_we  in  1  load attribute register
- attr_data  in  8  new attribute (bit7 blink, 6:4 bg, 3:0 fg)
- mem_address  out  12  video RAM byte address
- mem_wdata  out  8  write data
- mem_we  out  1  write strobe
- mem_rdata  in  8  read data; value in cycle N+1 reflects mem_address in cycle N
- cursor  out  11  cursor cell index, 0..COLS*ROWS-1
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (synchronous, any state, including mid-scroll or mid-clear):
  - mem_we=0, mem_address=0, mem_wdata=0, cursor=0, in_ready=0, busy=1, attr=DEFAULT_ATTR.
  - Enter CLEAR on the cycle after reset_n goes high.
- Handshake:
  - in_ready=1 only in IDLE.
  - A byte is accepted on the cycle in_valid & in_ready; in_ready=0 from the next cycle.
  - in_valid while busy is ignored; the byte is not lost to the source.
- Attribute register:
  - attr_we loads it in any cycle.
  - A printable character takes the attr value held on its accept cycle (latched with the char). An attr_we in that same cycle applies to later characters only.
  - CLEAR and FILL use the attr latched on entry to that state.
- States: IDLE, WCHAR, WATTR, CLEAR, SC_RD, SC_WR, FILL.
- Printable byte (any value other than 0x08, 0x0A, 0x0C, 0x0D):
  - WCHAR: address 2*cursor, data = char, we=1.
  - WATTR: address 2*cursor+1, data = attr, we=1, then cursor+1.
  - If the new cursor == COLS*ROWS: set cursor = COLS*(ROWS-1) and enter SC_RD. Otherwise return to IDLE.
  - in_ready is low for exactly 2 cycles after accept when no scroll occurs.
- 0x0D CR: cursor = cursor - (cursor mod COLS). One cycle, no RAM writes.
- 0x0A LF: cursor + COLS.
  - If the result is ≥ COLS*ROWS, the cursor keeps its column in the last row and the block scrolls.
  - Otherwise one cycle, no RAM writes.
- 0x08 BS: if cursor > 0 then cursor-1; no erase, no RAM writes. At cursor 0 it is a no-op.
- 0x0C FF: enter CLEAR, then cursor = 0.
- CLEAR:
  - Writes bytes 0..2*COLS*ROWS-1, one byte per cycle, we=1.
  - Even addresses get BLANK, odd addresses get attr.
  - 4000 cycles, then IDLE.
- Scroll (i = 0 .. 2*COLS*(ROWS-1)-1):
  - SC_RD: mem_address = i + 2*COLS, we=0.
  - SC_WR: mem_address = i, mem_wdata = mem_rdata, we=1.
  - Two cycles per byte, 7680 cycles in total.
  - Then FILL: the last row, 2*COLS bytes, same pattern as CLEAR, 160 cycles, then IDLE.
- Counters:
  - Address counters are 12-bit and never wrap past 2*COLS*ROWS-1.
  - The cursor is 11-bit; the compare against COLS*ROWS happens before assignment, so the cursor never shows an out-of-range value.
- mem_we=0 in IDLE and in every cycle not listed above. mem_address is held when idle.

Decomposition:
- Shared package text_console_pkg holds:
  - the state enum;
  - control-code constants (CC_BS=8'h08, CC_LF=8'h0A, CC_FF=8'h0C, CC_CR=8'h0D);
  - derived localparams CELLS=COLS*ROWS, ROW_BYTES=2*COLS, SCREEN_BYTES=2*CELLS.
- One natural sub-module, text_fill: start / base / count / attr in, pattern write stream out, done pulse. CLEAR and the scroll FILL both use it.

Test Plan:
- Reset release:
  - Exactly 4000 writes, even bytes 0x20 and odd bytes 0x07; cursor=0.
  - in_ready rises the first cycle after the last write; a model RAM dump matches.
- attr_we 0x1E, then send 0x41:
  - Writes addr0=0x41 and addr1=0x1E on consecutive cycles, cursor=1.
  - in_ready is low for exactly 2 cycles.
- Control codes, starting at cursor 85:
  - CR → 80; LF → 160; BS → 159. No mem_we pulses.
  - BS at cursor 0 → cursor stays 0.
- Bottom-right printable:
  - Preload row 1 with 'B'/0x07, set cursor 1999, send 0x5A.
  - Write at 3998/3999, then scroll; afterwards bytes 0..159 equal the old row 1 and bytes 3840..3999 alternate 0x20/attr.
  - cursor=1920; busy lasts 2+7680+160 cycles.
- LF at cursor 1925 → scroll performed, cursor=1925; back-to-back in_valid is held off until IDLE.
- Reset mid-operation:
  - Assert reset_n=0 for 1 cycle during scroll (i=1000): mem_we=0 next cycle and cursor=0.
  - Then a full CLEAR follows and attr returns to 0x07.
